// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard sequencer.
// Sequencer states and EX-stage operand-forward select encodings.
// No logic; imported by hazard_ctrl and fwd_unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;  // operand from ID/EX register read
    localparam fwd_sel_t FWD_MEM = 2'b10;  // operand from EX/MEM result
    localparam fwd_sel_t FWD_WB  = 2'b01;  // operand from MEM/WB result

endpackage

// File: rtl/fwd_unit.sv
// Operand-forward select for one EX source register (youngest producer wins).
// Latency: purely combinational, 0 cycles.
// Backpressure: none; independent of pipeline state.
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] sel
);

    // EX/MEM is younger than MEM/WB so it takes precedence; x0 is never forwarded.
    always_comb begin
        sel = FWD_REG;
        if (ex_rs != 5'd0) begin
            if (mem_reg_write && (mem_rd == ex_rs)) begin
                sel = FWD_MEM;
            end else if (wb_reg_write && (wb_rd == ex_rs)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencer: stall/flush per pipeline register, forwarding, halt, perf counters.
// Latency: stall/flush/fwd combinational (0 cycles); state, counters and timeout flag registered.
// Backpressure: dmem wait freezes PC..EX/MEM and bubbles MEM/WB until dmem_ready or timeout.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             ex_err,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             mem_reg_write,
    input  logic             wb_reg_write,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             exmem_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d, wait_inc;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             redirect_ok;
    logic             load_use;
    logic [1:0]       fwd_a_raw, fwd_b_raw;

    fwd_unit u_fwd_a (
        .ex_rs         (ex_rs1),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .sel           (fwd_a_raw)
    );

    fwd_unit u_fwd_b (
        .ex_rs         (ex_rs2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .sel           (fwd_b_raw)
    );

    assign wait_inc = wait_cnt_q + WCW'(1);
    assign load_use = ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Next state and per-cycle pipeline controls, priority HALT > mem wait > redirect > load-use.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        tmo_d       = tmo_q;
        redirect_ok = 1'b0;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;

        if (state_q == HALT) begin
            {pc_stall, ifid_stall, idex_stall, exmem_stall} = 4'b1111;
            memwb_flush = 1'b1;
        end else if (((state_q == MEM_WAIT) || mem_req) && !dmem_ready) begin
            // Freeze everything up to EX/MEM; a pending redirect stays held in EX.
            {pc_stall, ifid_stall, idex_stall, exmem_stall} = 4'b1111;
            memwb_flush = 1'b1;
            wait_cnt_d  = wait_inc;
            if (wait_inc == WCW'(MEM_TIMEOUT)) begin
                state_d = HALT;
                tmo_d   = 1'b1;
            end else begin
                state_d = MEM_WAIT;
            end
        end else begin
            // Normal flow, including the cycle in which a dmem wait completes.
            state_d    = RUN;
            wait_cnt_d = '0;
            if (ex_redirect) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                redirect_ok = 1'b1;
            end else if (load_use) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
            if ((state_q == RUN) && ex_err) begin
                idex_flush = 1'b1;
                state_d    = HALT;
            end
        end

        // Reset holds every stage as a bubble with no stalls.
        if (!rst) begin
            {pc_stall, ifid_stall, idex_stall, exmem_stall} = 4'b0000;
            {ifid_flush, idex_flush, memwb_flush}           = 3'b111;
        end
    end

    assign fwd_a_sel = rst ? fwd_a_raw : FWD_REG;
    assign fwd_b_sel = rst ? fwd_b_raw : FWD_REG;

    // Sequencer state, dmem wait counter and sticky timeout cause.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    // Saturating performance counters; HALT cycles are not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_stall && (state_q != HALT) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redirect_ok && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign halted       = (state_q == HALT);
    assign timeout_err  = tmo_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed corner sequences, random vs model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Registered outputs are compared at the start of each cycle, before new inputs are applied.
module tb_hazard_ctrl;

    localparam int MT = 4;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          ex_mem_read, ex_redirect, ex_err, mem_reg_write, wb_reg_write;
    logic          mem_req, dmem_ready;
    logic          pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic          ifid_flush, idex_flush, memwb_flush;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          halted, timeout_err;
    logic [CW-1:0] stall_cycles, flush_events;

    hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_err(ex_err),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall), .exmem_stall(exmem_stall),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .halted(halted), .timeout_err(timeout_err),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    // {pc,ifid,idex,exmem stalls, ifid,idex,memwb flushes, fwd_a, fwd_b}
    wire [10:0] comb_o = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                          ifid_flush, idex_flush, memwb_flush, fwd_a_sel, fwd_b_sel};

    localparam logic [10:0] C_FREE  = 11'b0000_000_00_00;
    localparam logic [10:0] C_RST   = 11'b0000_111_00_00;
    localparam logic [10:0] C_FROZE = 11'b1111_001_00_00;
    localparam logic [10:0] C_LU    = 11'b1100_010_00_00;
    localparam logic [10:0] C_REDIR = 11'b0000_110_00_00;
    localparam logic [10:0] C_ERR   = 11'b0000_010_00_00;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_mem_read = 0; ex_redirect = 0; ex_err = 0; mem_reg_write = 0; wb_reg_write = 0;
        mem_req = 0; dmem_ready = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    // Pipeline condition as plain integers: 0 running, 1 waiting on dmem, 2 halted.
    int m_mode, m_waited, m_sc, m_fe;
    bit m_tmo;

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (mem_reg_write && mem_rd == rs) return 2'b10;
        if (wb_reg_write && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    // Expected controls for the current inputs; advances the model to the next cycle.
    task automatic model_cycle(output logic [10:0] e);
        logic [3:0] st;
        logic [2:0] fl;
        bit lu;
        st = 4'b0; fl = 3'b0;
        if (!rst) begin
            m_mode = 0; m_waited = 0; m_sc = 0; m_fe = 0; m_tmo = 0;
            e = C_RST;
            return;
        end
        if (m_mode == 2) begin
            st = 4'b1111; fl = 3'b001;
        end else if ((m_mode == 1 || mem_req) && !dmem_ready) begin
            st = 4'b1111; fl = 3'b001;
            m_waited = m_waited + 1;
            m_sc = sat(m_sc);
            if (m_waited >= MT) begin m_mode = 2; m_tmo = 1; end
            else m_mode = 1;
        end else begin
            bit was_running;
            was_running = (m_mode == 0);
            m_mode = 0; m_waited = 0;
            lu = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
            if (ex_redirect) begin
                fl = 3'b110; m_fe = sat(m_fe);
            end else if (lu) begin
                st = 4'b1100; fl = 3'b010; m_sc = sat(m_sc);
            end
            if (was_running && ex_err) begin
                fl[1] = 1'b1; m_mode = 2;
            end
        end
        e = {st, fl, m_fwd(ex_rs1), m_fwd(ex_rs2)};
    endtask

    // ---------------- single-cycle vector table ----------------
    typedef struct {
        logic [4:0]  id1, id2, xr1, xr2, xrd, mrd, wrd;
        logic        ld, redir, mw, ww;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [10:0] e;

        tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_FREE};
        tbl[1] = '{0, 0, 3, 0, 0, 3, 3, 0, 0, 1, 1, 11'b0000_000_10_00};
        tbl[2] = '{0, 0, 0, 7, 0, 7, 7, 0, 0, 0, 1, 11'b0000_000_00_01};
        tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_FREE};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_FREE};
        tbl[5] = '{5, 9, 0, 0, 5, 0, 0, 1, 0, 0, 0, C_LU};
        tbl[6] = '{5, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, C_FREE};
        tbl[7] = '{0, 0, 4, 4, 0, 4, 0, 0, 0, 1, 0, 11'b0000_000_10_10};
        tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_REDIR};
        tbl[9] = '{0, 0, 6, 2, 0, 6, 6, 0, 0, 0, 1, 11'b0000_000_01_00};

        idle();
        rst = 1'b0;
        #2;
        chk("reset_comb", comb_o, C_RST);
        chk("reset_halted", halted, 0);
        chk("reset_tmo", timeout_err, 0);
        chk("reset_stall_cnt", stall_cycles, 0);
        chk("reset_flush_cnt", flush_events, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            id_rs1 = tbl[i].id1; id_rs2 = tbl[i].id2; ex_rs1 = tbl[i].xr1; ex_rs2 = tbl[i].xr2;
            ex_rd = tbl[i].xrd; mem_rd = tbl[i].mrd; wb_rd = tbl[i].wrd;
            ex_mem_read = tbl[i].ld; ex_redirect = tbl[i].redir;
            mem_reg_write = tbl[i].mw; wb_reg_write = tbl[i].ww;
            #1 chk($sformatf("vec%0d", i), comb_o, tbl[i].exp);
        end

        // Load-use bubble for one cycle, counted once.
        do_reset();
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5;
        #1 chk("lu_comb", comb_o, C_LU);
        @(negedge clk); idle();
        chk("lu_stall_cnt", stall_cycles, 1);
        #1 chk("lu_after", comb_o, C_FREE);

        // Redirect beats load-use in the same cycle.
        @(negedge clk);
        ex_redirect = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5;
        #1 chk("redir_lu_comb", comb_o, C_REDIR);
        @(negedge clk); idle();
        chk("redir_flush_cnt", flush_events, 1);
        chk("redir_stall_cnt", stall_cycles, 1);

        // dmem wait for three cycles with a redirect held in EX, honoured on release.
        mem_req = 1; dmem_ready = 0; ex_redirect = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("wait%0d_comb", i), comb_o, C_FROZE);
            @(negedge clk);
        end
        dmem_ready = 1;
        #1 chk("wait_release_comb", comb_o, C_REDIR);
        @(negedge clk); idle();
        chk("wait_stall_cnt", stall_cycles, 4);
        chk("wait_flush_cnt", flush_events, 2);
        chk("wait_not_halted", halted, 0);
        dmem_ready = 0;
        #1 chk("wait_back_to_run", comb_o, C_FREE);

        // Error in RUN: one bubble into EX, then halt without timeout cause.
        @(negedge clk); idle();
        ex_err = 1;
        #1 chk("err_comb", comb_o, C_ERR);
        @(negedge clk); idle();
        chk("err_halted", halted, 1);
        chk("err_tmo", timeout_err, 0);
        #1 chk("err_halt_comb", comb_o, C_FROZE);
        @(negedge clk);
        chk("err_halt_no_count", stall_cycles, 4);

        // dmem timeout: halts after MT wait cycles and stays halted.
        do_reset();
        mem_req = 1; dmem_ready = 0;
        for (int i = 0; i < MT; i++) begin
            chk($sformatf("tmo_pre%0d_halted", i), halted, 0);
            #1 chk($sformatf("tmo_pre%0d_comb", i), comb_o, C_FROZE);
            @(negedge clk);
        end
        chk("tmo_halted", halted, 1);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_stall_cnt", stall_cycles, MT);
        dmem_ready = 1; mem_req = 0; ex_redirect = 1;
        repeat (3) @(negedge clk);
        chk("tmo_sticky_halted", halted, 1);
        chk("tmo_sticky_err", timeout_err, 1);
        chk("tmo_frozen_cnt", stall_cycles, MT);
        chk("tmo_frozen_fe", flush_events, 0);
        #1 chk("tmo_halt_comb", comb_o, C_FROZE);

        // Asynchronous reset in the middle of a dmem wait.
        do_reset();
        mem_req = 1; dmem_ready = 0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_wait_cnt", stall_cycles, 2);
        #2 rst = 1'b0;
        #1 chk("async_rst_comb", comb_o, C_RST);
        chk("async_rst_cnt", stall_cycles, 0);
        chk("async_rst_halted", halted, 0);
        @(negedge clk);
        rst = 1'b1; mem_req = 0; dmem_ready = 0;
        #1 chk("async_rst_run", comb_o, C_FREE);

        // Saturation of the stall counter.
        do_reset();
        ex_mem_read = 1; ex_rd = 9; id_rs1 = 9;
        repeat (CMAX + 5) @(negedge clk);
        idle();
        chk("stall_cnt_sat", stall_cycles, CMAX);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (n != 0) begin
                chk("rand_halted", halted, (m_mode == 2) ? 1 : 0);
                chk("rand_tmo", timeout_err, m_tmo);
                chk("rand_stall_cnt", stall_cycles, m_sc);
                chk("rand_flush_cnt", flush_events, m_fe);
            end
            rst = (n == 0 || $urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd  = 5'($urandom_range(0, 3));
            ex_mem_read   = ($urandom_range(0, 9) < 4);
            ex_redirect   = ($urandom_range(0, 9) < 2);
            ex_err        = ($urandom_range(0, 63) == 0);
            mem_reg_write = $urandom_range(0, 1);
            wb_reg_write  = $urandom_range(0, 1);
            mem_req       = ($urandom_range(0, 9) < 3);
            dmem_ready    = $urandom_range(0, 1);
            #1;
            model_cycle(e);
            chk("rand_comb", comb_o, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
